vga_plot_arbiter: RTL and testbench

VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

---
 rtl/vga_plot_arbiter_pkg.sv | 25 ++
 rtl/vga_plot_arbiter_rr_pick.sv | 30 +++
 rtl/vga_plot_arbiter.sv | 155 +++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_plot_arbiter_pkg.sv
// Shared game drawing constants: screen limits, colour width, pixel record and
// the plot-arbiter state encoding used by the scroll, energy-bar and sprite drawers.
package vga_plot_arbiter_pkg;

   localparam int X_MAX_DEF = 159;
   localparam int Y_MAX_DEF = 119;
   localparam int COLOUR_W  = 3;
   localparam int X_W       = 8;
   localparam int Y_W       = 7;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_OWN  = 2'b01;

   typedef struct packed {
      logic [X_W-1:0]      x;
      logic [Y_W-1:0]      y;
      logic [COLOUR_W-1:0] colour;
   } pixel_t;

   // Round-robin successor of a client index.
   function automatic logic [1:0] next_idx(input logic [1:0] idx, input int n);
      return (int'(idx) >= n - 1) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_start,
// wrapping, as a one-hot grant plus its index.
module rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_start,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      // k is the distance from the start index; j is the candidate client.
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!o_any && i_req[j] && (j == ((int'(i_start) + k) % NUM_REQ))) begin
               o_any    = 1'b1;
               o_gnt[j] = 1'b1;
               o_idx    = IDX_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Arbitrates several pixel drawers onto one vga_adapter write port, with
// round-robin selection, bounded lock bursts and off-screen clipping.
module vga_plot_arbiter
   import vga_plot_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int MAX_BURST = 16,
   parameter int X_MAX     = X_MAX_DEF,
   parameter int Y_MAX     = Y_MAX_DEF
) (
   input  logic                        CLOCK_50,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          lock,
   input  logic [X_W*NUM_REQ-1:0]      px_x,
   input  logic [Y_W*NUM_REQ-1:0]      px_y,
   input  logic [COLOUR_W*NUM_REQ-1:0] px_colour,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [X_W-1:0]              x,
   output logic [Y_W-1:0]              y,
   output logic [COLOUR_W-1:0]         colour,
   output logic                        plot,
   output logic [1:0]                  owner,
   output logic                        busy,
   output logic [7:0]                  clip_cnt
);

   localparam logic [X_W-1:0] X_LIM      = X_W'(X_MAX);
   localparam logic [Y_W-1:0] Y_LIM      = Y_W'(Y_MAX);
   localparam logic [4:0]     BURST_LAST = 5'(MAX_BURST - 1);
   localparam logic [1:0]     OWNER_RST  = 2'(NUM_REQ - 1);

   logic [1:0]          r_state;
   logic [1:0]          r_owner;
   logic [4:0]          r_burst;
   logic [7:0]          r_clip;
   logic                r_plot;
   logic [X_W-1:0]      r_x;
   logic [Y_W-1:0]      r_y;
   logic [COLOUR_W-1:0] r_colour;

   logic [1:0]          w_start;
   logic [NUM_REQ-1:0]  w_rr_gnt;
   logic [1:0]          w_rr_idx;
   logic                w_rr_any;
   logic [NUM_REQ-1:0]  w_gnt;
   logic [1:0]          w_sel;
   logic                w_any;
   pixel_t              w_pix;
   logic                w_clip;

   assign w_start = next_idx(r_owner, NUM_REQ);

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (2)
   ) u_rr_pick (
      .i_req   (req),
      .i_start (w_start),
      .o_gnt   (w_rr_gnt),
      .o_idx   (w_rr_idx),
      .o_any   (w_rr_any)
   );

   // A locked owner shuts everyone else out, even on cycles it does not request.
   always_comb begin
      w_gnt = '0;
      w_sel = r_owner;
      w_any = 1'b0;
      if (!reset) begin
         case (r_state)
            ST_IDLE: begin
               w_gnt = w_rr_gnt;
               w_sel = w_rr_idx;
               w_any = w_rr_any;
            end
            ST_OWN: begin
               if (req[r_owner]) begin
                  w_gnt[r_owner] = 1'b1;
                  w_any          = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_pix = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_sel == 2'(i)) begin
            w_pix.x      = px_x[X_W*i +: X_W];
            w_pix.y      = px_y[Y_W*i +: Y_W];
            w_pix.colour = px_colour[COLOUR_W*i +: COLOUR_W];
         end
      end
      w_clip = (w_pix.x > X_LIM) || (w_pix.y > Y_LIM);
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_owner  <= OWNER_RST;
         r_burst  <= '0;
         r_clip   <= '0;
         r_plot   <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
         r_colour <= '0;
      end else begin
         r_plot <= w_any && !w_clip;
         if (w_any && !w_clip) begin
            r_x      <= w_pix.x;
            r_y      <= w_pix.y;
            r_colour <= w_pix.colour;
         end
         if (w_any && w_clip && (r_clip != 8'hFF))
            r_clip <= r_clip + 8'd1;

         case (r_state)
            ST_IDLE: begin
               if (w_rr_any) begin
                  r_owner <= w_rr_idx;
                  if (lock[w_rr_idx]) begin
                     r_state <= ST_OWN;
                     r_burst <= 5'd1;
                  end
               end
            end
            ST_OWN: begin
               if (!lock[r_owner] || (r_burst == BURST_LAST)) begin
                  r_state <= ST_IDLE;
                  r_burst <= '0;
               end else begin
                  r_burst <= r_burst + 5'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_burst <= '0;
            end
         endcase
      end
   end

   assign gnt      = w_gnt;
   assign x        = r_x;
   assign y        = r_y;
   assign colour   = r_colour;
   assign plot     = r_plot;
   assign owner    = r_owner;
   assign busy     = (r_state == ST_OWN);
   assign clip_cnt = r_clip;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: a behavioural arbitration model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_vga_plot_arbiter;

   localparam int N = 3;

   logic          CLOCK_50 = 1'b0;
   logic          reset;
   logic [N-1:0]  req, lock;
   logic [8*N-1:0] px_x;
   logic [7*N-1:0] px_y;
   logic [3*N-1:0] px_colour;
   logic [N-1:0]  gnt;
   logic [7:0]    x;
   logic [6:0]    y;
   logic [2:0]    colour;
   logic          plot;
   logic [1:0]    owner;
   logic          busy;
   logic [7:0]    clip_cnt;

   vga_plot_arbiter dut (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .req       (req),
      .lock      (lock),
      .px_x      (px_x),
      .px_y      (px_y),
      .px_colour (px_colour),
      .gnt       (gnt),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .plot      (plot),
      .owner     (owner),
      .busy      (busy),
      .clip_cnt  (clip_cnt)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: who holds the port, for how many cycles, and what the screen saw last.
   int m_owner, m_held, m_x, m_y, m_col, m_clip;
   bit m_locked, m_plot, m_init = 1'b0;

   function automatic bit has(input logic [N-1:0] v, input int c);
      return ((v >> c) & 3'd1) != 3'd0;
   endfunction

   function automatic int model_pick();
      if (reset) return -1;
      if (m_locked) return has(req, m_owner) ? m_owner : -1;
      for (int k = 1; k <= N; k++) begin
         if (has(req, (m_owner + k) % N)) return (m_owner + k) % N;
      end
      return -1;
   endfunction

   always @(posedge CLOCK_50) begin : model
      int c, cx, cy, cc;
      if (reset) begin
         m_init = 1'b1; m_owner = N - 1; m_locked = 1'b0; m_held = 0;
         m_plot = 1'b0; m_x = 0; m_y = 0; m_col = 0; m_clip = 0;
      end else if (m_init) begin
         c = model_pick();
         m_plot = 1'b0;
         if (c >= 0) begin
            cx = int'((px_x >> (8*c)) & 24'hFF);
            cy = int'((px_y >> (7*c)) & 21'h7F);
            cc = int'((px_colour >> (3*c)) & 9'h7);
            if (cx > 159 || cy > 119) begin
               if (m_clip < 255) m_clip++;
            end else begin
               m_plot = 1'b1; m_x = cx; m_y = cy; m_col = cc;
            end
         end
         if (m_locked) begin
            m_held++;
            if (!has(lock, m_owner) || m_held >= 16) begin
               m_locked = 1'b0; m_held = 0;
            end
         end else if (c >= 0) begin
            m_owner = c;
            if (has(lock, c)) begin
               m_locked = 1'b1; m_held = 1;
            end
         end
      end
   end

   always @(negedge CLOCK_50) begin : compare
      int c;
      logic [N-1:0] eg;
      if (m_init) begin
         c  = model_pick();
         eg = (c < 0) ? 3'b000 : 3'(1 << c);
         chk("gnt", int'(gnt), int'(eg));
         chk("plot", int'(plot), int'(m_plot));
         chk("busy", int'(busy), int'(m_locked));
         chk("owner", int'(owner), m_owner);
         chk("clip_cnt", int'(clip_cnt), m_clip);
         chk("x", int'(x), m_x);
         chk("y", int'(y), m_y);
         chk("colour", int'(colour), m_col);
      end
   end

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic set_px(input int c, input int xv, input int yv, input int cv);
      px_x[8*c +: 8]      = 8'(xv);
      px_y[7*c +: 7]      = 7'(yv);
      px_colour[3*c +: 3] = 3'(cv);
   endtask

   logic [N-1:0] exp_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
   logic [N-1:0] g [40];
   int lead;

   initial begin
      reset = 1'b1; req = '0; lock = '0;
      px_x = '0; px_y = '0; px_colour = '0;
      repeat (2) @(posedge CLOCK_50);
      #1;
      chk("rst_plot", int'(plot), 0);
      chk("rst_owner", int'(owner), 2);
      chk("rst_busy", int'(busy), 0);
      chk("rst_clip", int'(clip_cnt), 0);
      chk("rst_gnt", int'(gnt), 0);

      // Plain round robin with everyone requesting.
      reset = 1'b0;
      for (int c = 0; c < N; c++) set_px(c, 10 + c, 20 + c, c + 1);
      req = 3'b111; lock = 3'b000;
      for (int i = 0; i < 4; i++) begin
         #2 chk("rr_gnt", int'(gnt), int'(exp_seq[i]));
         tick();
         chk("rr_plot", int'(plot), 1);
      end

      // Client 1 locking against client 0.
      req = 3'b011; lock = 3'b010;
      for (int i = 0; i < 40; i++) begin
         #2 g[i] = gnt;
         tick();
      end
      lead = 0;
      while (lead < 40 && g[lead] == 3'b010) lead++;
      chk("lock_run", lead, 16);
      chk("lock_yield", int'(g[16]), 1);
      chk("lock_relock", int'(g[17]), 2);

      // Owner 2 goes quiet mid-burst while client 0 waits.
      req = 3'b000; lock = 3'b000; tick();
      req = 3'b100; lock = 3'b100; tick();
      req = 3'b101; tick();
      req = 3'b001;
      for (int i = 0; i < 3; i++) begin
         #2 chk("quiet_gnt", int'(gnt), 0);
         tick();
         chk("quiet_plot", int'(plot), 0);
      end
      req = 3'b101;
      for (int i = 0; i < 14; i++) begin
         #2 g[i] = gnt;
         tick();
      end
      lead = 0;
      while (lead < 14 && g[lead] == 3'b100) lead++;
      chk("quiet_run", lead, 11);
      chk("quiet_yield", int'(g[11]), 1);

      // Clipping on each axis, then the exact screen corner.
      req = 3'b000; lock = 3'b000; tick();
      req = 3'b001;
      set_px(0, 160, 5, 5);
      #2 chk("clip1_gnt", int'(gnt), 1);
      tick(); chk("clip1_plot", int'(plot), 0);
      set_px(0, 10, 120, 5);
      #2 chk("clip2_gnt", int'(gnt), 1);
      tick(); chk("clip2_plot", int'(plot), 0);
      set_px(0, 159, 119, 6);
      #2 chk("clip3_gnt", int'(gnt), 1);
      tick();
      chk("clip3_plot", int'(plot), 1);
      chk("clip_cnt2", int'(clip_cnt), 2);
      chk("corner_x", int'(x), 159);
      chk("corner_y", int'(y), 119);

      // Reset in the middle of a client 1 burst.
      set_px(0, 10, 20, 1);
      req = 3'b010; lock = 3'b010; tick();
      repeat (6) tick();
      reset = 1'b1;
      #2 chk("mid_rst_gnt", int'(gnt), 0);
      tick();
      chk("mid_rst_plot", int'(plot), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_owner", int'(owner), 2);
      reset = 1'b0; req = 3'b011; lock = 3'b000;
      #2 chk("post_rst_gnt", int'(gnt), 1);
      tick();

      // Saturation of the clip counter.
      req = 3'b001; set_px(0, 200, 5, 2);
      repeat (300) tick();
      chk("clip_sat", int'(clip_cnt), 255);
      req = 3'b000; tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
